// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory responder slice. It holds:
//   - the RISC-V Funct3 width/sign codes used by loads and stores,
//   - the responder FSM state type,
//   - a helper that builds the RAM byte-enable mask for a store,
//   - a helper that moves a load lane down to bit 0 and extends it.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Funct3[1:0] alone selects the access size (byte/half/word). A word
  // store touches every lane, so the low address bits do not matter there,
  // and a half store looks only at addr[1].
  function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                             input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b1111;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Picks the addressed byte or half out of the RAM word, moves it down to
  // bit 0, and then sign- or zero-extends it as Funct3 asks. Codes that are
  // not byte or half loads fall through as a full word. Illegal codes never
  // get here, because they are turned into errors before any read happens.
  function automatic logic [31:0] load_format(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] result;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_BU:   result = {24'h000000, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_HU:   result = {16'h0000, h};
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram
// Single-port synchronous RAM. Each word is 32 bits and has four byte
// enables. Reads are registered, so read data appears one cycle after 'en'.
// INIT_FILE is kept as a parameter for interface compatibility; contents
// start undefined.
// Ports:
//   clk    rising-edge clock
//   en     read strobe; captures mem[addr] into rdata
//   we     per-byte write enables (bit n writes wdata[8n+7:8n])
//   addr   word index
//   wdata  write data
//   rdata  registered read data
module dmem_ram #(
  parameter int    WORD_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [WORD_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << WORD_W;

  logic [31:0] mem [0:DEPTH-1];

  // Byte-lane writes and the registered read share one port. The responder
  // never issues both in the same cycle.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// The far end of the core's MemRead/MemWrite/ALU-address interface.
// It accepts one load or store per req_valid/req_ready handshake and applies
// the RISC-V Funct3 width and sign rules. It returns a registered one-cycle
// response: a store takes 1 cycle, a load takes 2 cycles.
// Build option: DMEM_MISALIGN_TRAP_EN. When it is defined, a misaligned half
// or word access is rejected with rsp_err. When it is undefined, the
// misaligned low address bits are simply ignored.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   req_valid/req_ready  request handshake; ready only while IDLE
//   MemRead, MemWrite    load / store flags (both set = conflict error)
//   Funct3               access width and sign
//   addr                 byte address, wraps modulo memory size
//   wr_data              store data, right-aligned
//   rsp_valid            one-cycle response strobe
//   rd_data              formatted load data, 0 otherwise
//   rsp_err              request rejected (valid with rsp_valid)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  output logic              rsp_valid,
  output logic [31:0]       rd_data,
  output logic              rsp_err
);

  localparam int WORD_W = ADDR_W - 2;

  dmem_state_t state;

  logic        accept;
  logic        is_load;
  logic        is_store;
  logic        is_conflict;
  logic        f3_load_ok;
  logic        f3_store_ok;
  logic        misaligned;
  logic        req_err;
  logic        do_read;
  logic        do_write;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Request decode. This works out whether the request on the bus is a
  // legal load or store. Errors always suppress the RAM access. The RAM
  // write is also gated by reset, so that a store presented on a reset
  // edge never reaches memory. Store data is copied into every lane, and
  // the byte enables choose which copy is kept.
  always_comb begin
    is_load     = MemRead && !MemWrite;
    is_store    = MemWrite && !MemRead;
    is_conflict = MemRead && MemWrite;
    f3_load_ok  = Funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    f3_store_ok = Funct3 inside {F3_B, F3_H, F3_W};
`ifdef DMEM_MISALIGN_TRAP_EN
    misaligned  = ((Funct3[1:0] == 2'b01) && addr[0]) ||
                  ((Funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    misaligned  = 1'b0;
`endif
    req_err     = is_conflict ||
                  (is_load  && (!f3_load_ok  || misaligned)) ||
                  (is_store && (!f3_store_ok || misaligned));
    do_read     = accept && is_load && !req_err;
    do_write    = accept && is_store && !req_err && !reset;
    ram_we      = do_write ? byte_enable(Funct3, addr[1:0]) : 4'b0000;
    case (Funct3[1:0])
      2'b00:   ram_wdata = {4{wr_data[7:0]}};
      2'b01:   ram_wdata = {2{wr_data[15:0]}};
      default: ram_wdata = wr_data;
    endcase
  end

  dmem_ram #(
    .WORD_W    (WORD_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (do_read),
    .we    (ram_we),
    .addr  (addr[ADDR_W-1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Responder FSM. Every request except a good load goes straight to RESP
  // and responds one cycle later. A good load passes through READ, which
  // waits for the registered RAM data; the width and lane are held in
  // f3_q and lane_q so the data can be formatted then. RESP always returns
  // to IDLE, so rsp_valid lasts exactly one cycle. Reset drops any
  // response that is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_data   <= 32'h0;
      f3_q      <= 3'b000;
      lane_q    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rd_data   <= 32'h0;
          if (accept) begin
            if (do_read) begin
              state  <= READ;
              f3_q   <= Funct3;
              lane_q <= addr[1:0];
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= req_err;
            end
          end
        end
        READ: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rd_data   <= load_format(ram_rdata, f3_q, lane_q);
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rd_data   <= 32'h0;
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rd_data   <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Self-checking bench for dmem_responder. A byte-array model of memory
// predicts the load data, error flag and latency of every request from the
// access rules. The bench runs directed cases and then a random mix.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [9:0]  addr;
  logic [31:0] wr_data;
  logic        rsp_valid;
  logic [31:0] rd_data;
  logic        rsp_err;

  int          compared;
  int          mismatched;
  logic [31:0] lastData;
  logic [7:0]  modelMem [0:1023];

  dmem_responder #(
    .ADDR_W    (10),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Funct3    (Funct3),
    .addr      (addr),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rd_data   (rd_data),
    .rsp_err   (rsp_err)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model. It finds the access size, legality and natural
  // alignment with plain arithmetic, and it updates or reads the byte array
  // in little-endian order.
  task automatic modelRequest(input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [9:0] a,
                              input logic [31:0] wd,
                              output logic [31:0] expData,
                              output logic expErr, output int expLat);
    int          size;
    int          base;
    logic [31:0] v;
    bit          legal;
    expData = 32'h0;
    expErr  = 1'b0;
    expLat  = 1;
    if (rd && wr) begin
      expErr = 1'b1;
      return;
    end
    if (!rd && !wr) return;
    legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
               : (f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal) begin
      expErr = 1'b1;
      return;
    end
    size = 1 << f3[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((int'(a) % size) != 0) begin
      expErr = 1'b1;
      return;
    end
`endif
    base = (int'(a) / size) * size;
    if (wr) begin
      for (int i = 0; i < size; i++) modelMem[base + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(modelMem[base + i]) << (8*i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFFFFFF << (8*size));
      expData = v;
      expLat  = 2;
    end
  endtask

  // Sends one request, scrambles the bus once it has been accepted, waits
  // (with a bound) for the response, and checks latency, error flag, data
  // and the one-cycle strobe.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [9:0] a,
                               input logic [31:0] wd);
    logic [31:0] expData;
    logic        expErr;
    int          expLat;
    int          lat;
    modelRequest(rd, wr, f3, a, wd, expData, expErr, expLat);
    checkOutput("idle_ready", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1;
    MemRead   = rd;
    MemWrite  = wr;
    Funct3    = f3;
    addr      = a;
    wr_data   = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    MemRead   = 1'($urandom);
    MemWrite  = 1'($urandom);
    Funct3    = 3'($urandom);
    addr      = 10'($urandom);
    wr_data   = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      checkOutput("busy_ready", {31'h0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", lat, expLat);
    checkOutput("rsp_err", {31'h0, rsp_err}, {31'h0, expErr});
    checkOutput("rd_data", rd_data, expData);
    lastData = rd_data;
    @(posedge clk);
    #1;
    checkOutput("strobe_drop", {31'h0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [2:0] legalF3 [5];
    int         op;
    logic [2:0] f3;
    logic [9:0] a;
    legalF3[0] = 3'b000;
    legalF3[1] = 3'b001;
    legalF3[2] = 3'b010;
    legalF3[3] = 3'b100;
    legalF3[4] = 3'b101;
    compared   = 0;
    mismatched = 0;
    lastData   = 32'h0;

    // Hold reset for two edges while a store is offered on the bus.
    reset     = 1'b1;
    req_valid = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b1;
    Funct3    = 3'b010;
    addr      = 10'h010;
    wr_data   = 32'hA5A5A5A5;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("rst_valid", {31'h0, rsp_valid}, 32'd0);
    checkOutput("rst_data", rd_data, 32'h0);
    checkOutput("rst_err", {31'h0, rsp_err}, 32'd0);
    reset     = 1'b0;
    req_valid = 1'b0;

    // Fill memory so that every later load has a known value.
    for (int w = 0; w < 256; w++) applyStimulus(1'b0, 1'b1, 3'b010, 10'(w * 4), $urandom);

    // Directed cases.
    applyStimulus(1'b0, 1'b1, 3'b010, 10'h010, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 3'b010, 10'h010, 32'h0);
    checkOutput("lw_deadbeef", lastData, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 3'b000, 10'h013, 32'h00000080);
    applyStimulus(1'b1, 1'b0, 3'b000, 10'h013, 32'h0);
    checkOutput("lb_sign", lastData, 32'hFFFFFF80);
    applyStimulus(1'b1, 1'b0, 3'b100, 10'h013, 32'h0);
    checkOutput("lbu_zero", lastData, 32'h00000080);
    applyStimulus(1'b1, 1'b0, 3'b010, 10'h010, 32'h0);
    checkOutput("lw_merged", lastData, 32'h80ADBEEF);
    applyStimulus(1'b0, 1'b1, 3'b001, 10'h012, 32'h00008001);
    applyStimulus(1'b1, 1'b0, 3'b001, 10'h012, 32'h0);
    checkOutput("lh_sign", lastData, 32'hFFFF8001);
    applyStimulus(1'b1, 1'b0, 3'b101, 10'h012, 32'h0);
    checkOutput("lhu_zero", lastData, 32'h00008001);
    applyStimulus(1'b1, 1'b1, 3'b010, 10'h010, 32'h11111111);
    applyStimulus(1'b0, 1'b1, 3'b011, 10'h010, 32'h22222222);
    applyStimulus(1'b1, 1'b0, 3'b011, 10'h010, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'b111, 10'h010, 32'h33333333);
    applyStimulus(1'b1, 1'b0, 3'b010, 10'h010, 32'h0);
    checkOutput("lw_unchanged", lastData, 32'h8001BEEF);
    applyStimulus(1'b1, 1'b0, 3'b010, 10'h011, 32'h0);

    // A store offered on a reset edge must leave memory untouched.
    reset     = 1'b1;
    req_valid = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b1;
    Funct3    = 3'b010;
    addr      = 10'h010;
    wr_data   = 32'h12345678;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    checkOutput("rst_store_valid", {31'h0, rsp_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b010, 10'h010, 32'h0);
    checkOutput("rst_store_nowrite", lastData, 32'h8001BEEF);

    // Reset while a load is in READ: its response is dropped.
    req_valid = 1'b1;
    MemRead   = 1'b1;
    MemWrite  = 1'b0;
    Funct3    = 3'b010;
    addr      = 10'h010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("read_busy", {31'h0, req_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_read_valid", {31'h0, rsp_valid}, 32'd0);
    checkOutput("rst_read_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("rst_read_data", rd_data, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_read_nolate", {31'h0, rsp_valid}, 32'd0);

    // Random mix of loads, stores, no-ops, conflicts and odd Funct3 codes.
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      f3 = ($urandom_range(0, 9) < 8) ? legalF3[$urandom_range(0, 4)] : 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(12, 23)) : 10'($urandom);
      if (op < 4)       applyStimulus(1'b1, 1'b0, f3, a, $urandom);
      else if (op < 8)  applyStimulus(1'b0, 1'b1, f3, a, $urandom);
      else if (op == 8) applyStimulus(1'b0, 1'b0, f3, a, $urandom);
      else              applyStimulus(1'b1, 1'b1, f3, a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
